// File: rtl/keypad_scan.sv
// keypad_scan: walks a 4x4 keypad one column at a time, debounces over whole
// scans and presents the accepted key as a hex code with a valid/ack handshake.
module keypad_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED} state_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd3;
    if (v[2]) r = 2'd2;
    if (v[1]) r = 2'd1;
    if (v[0]) r = 2'd0;
    return r;
  endfunction

  // Hit counts only need to distinguish none / one / many, so saturate at 2.
  function automatic logic [1:0] sat_hits(input logic [3:0] v);
    logic [2:0] n;
    n = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    return (n > 3'd2) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  logic [3:0]       r_row_s1, r_row_s2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [3:0]       r_col_out;
  logic [1:0]       r_hits;
  logic [3:0]       r_hit_code;
  state_t           r_state;
  logic [3:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rel;
  logic             r_key_held;
  logic             r_accept_p0;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_overrun;

  logic       w_slot_end, w_eval, w_single, w_none;
  logic [3:0] w_lows;
  logic [1:0] w_col_hits, w_scan_hits;
  logic [3:0] w_scan_code;

  assign w_slot_end  = (r_div == DIV_LAST);
  assign w_eval      = w_slot_end && (r_col == 2'd3);
  assign w_lows      = ~r_row_s2;
  assign w_col_hits  = sat_hits(w_lows);
  assign w_scan_hits = sat_add2(r_hits, w_col_hits);
  assign w_scan_code = (w_col_hits == 2'd1) ? key_map(low_row(w_lows), r_col) : r_hit_code;
  assign w_single    = (w_scan_hits == 2'd1);
  assign w_none      = (w_scan_hits == 2'd0);

  // Stage p0: two-flop synchronizer on the asynchronous rows (idle = all high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  // Stage p1: column walk and per-scan accumulation of low row bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_col      <= 2'd0;
      r_col_out  <= 4'b1110;
      r_hits     <= 2'd0;
      r_hit_code <= 4'h0;
    end else if (w_slot_end) begin
      r_div      <= '0;
      r_col      <= r_col + 2'd1;
      r_col_out  <= {r_col_out[2:0], r_col_out[3]};
      r_hits     <= (r_col == 2'd3) ? 2'd0 : w_scan_hits;
      r_hit_code <= w_scan_code;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Stage p2: debounce FSM, advanced once per completed scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'h0;
      r_cnt       <= '0;
      r_rel       <= '0;
      r_key_held  <= 1'b0;
      r_accept_p0 <= 1'b0;
    end else begin
      r_accept_p0 <= 1'b0;
      if (w_eval) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_state <= S_CAND;
              r_cand  <= w_scan_code;
              r_cnt   <= CNT_W'(1);
            end
          end
          S_CAND: begin
            if (w_single && (w_scan_code == r_cand)) begin
              if (r_cnt >= CNT_LAST) begin
                r_state     <= S_PRESSED;
                r_key_held  <= 1'b1;
                r_rel       <= '0;
                r_accept_p0 <= 1'b1;
              end
              r_cnt <= sat_inc(r_cnt);
            end else if (w_single) begin
              r_cand <= w_scan_code;
              r_cnt  <= CNT_W'(1);
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end
          S_PRESSED: begin
            if (w_none) begin
              if (r_rel >= CNT_LAST) begin
                r_state    <= S_IDLE;
                r_key_held <= 1'b0;
                r_rel      <= '0;
                r_cnt      <= '0;
              end else begin
                r_rel <= sat_inc(r_rel);
              end
            end else begin
              r_rel <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage p3: output handshake; an ack coinciding with an accept suppresses overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (r_accept_p0) begin
      r_key_code  <= r_cand;
      r_key_valid <= 1'b1;
      if (r_key_valid && !key_ack) r_overrun <= 1'b1;
      else if (r_key_valid)        r_overrun <= 1'b0;
    end else if (key_ack && r_key_valid) begin
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed keypad scenarios checked every cycle against a
// scan-level behavioural model, plus literal expectations per scenario.
module tb_keypad_scan;
  localparam int S    = 4;
  localparam int D    = 3;
  localparam int SCAN = 4 * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_ack = 1'b0;
  logic [15:0] keys = 16'h0;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held, overrun;

  int checks = 0;
  int errors = 0;

  keypad_scan #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
  function automatic logic [3:0] rows_of(input logic [15:0] k, input logic [3:0] col);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (k[r*4+c] && !col[c]) rows[r] = 1'b0;
    return rows;
  endfunction

  assign row_in = rows_of(keys, col_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
  int          m_t = 0;
  logic [15:0] m_kd1 = 16'h0, m_kd2 = 16'h0, m_mask = 16'h0;
  bit          m_pressed = 0, m_acc_pend = 0;
  int          m_run_len = 0, m_none_run = 0;
  logic [3:0]  m_run_code = 4'h0, m_acc_code = 4'h0;
  logic [3:0]  m_code = 4'h0;
  bit          m_valid = 0, m_ovr = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = 0; m_kd1 = 16'h0; m_kd2 = 16'h0; m_mask = 16'h0;
        m_pressed = 0; m_acc_pend = 0; m_run_len = 0; m_none_run = 0;
        m_run_code = 4'h0; m_acc_code = 4'h0;
        m_code = 4'h0; m_valid = 0; m_ovr = 0;
      end else begin
        if (m_acc_pend) begin
          m_ovr      = m_valid && !key_ack;
          m_code     = m_acc_code;
          m_valid    = 1;
          m_acc_pend = 0;
        end else if (key_ack && m_valid) begin
          m_valid = 0;
          m_ovr   = 0;
        end
        if (m_t % S == S - 1) begin
          for (int r = 0; r < 4; r++)
            if (m_kd2[r*4 + (m_t / S) % 4]) m_mask[r*4 + (m_t / S) % 4] = 1'b1;
        end
        if (m_t % SCAN == SCAN - 1) begin
          int n;
          logic [3:0] code;
          n = $countones(m_mask);
          code = 4'h0;
          for (int i = 0; i < 16; i++) if (m_mask[i]) code = KEYMAP[i];
          if (!m_pressed) begin
            if (n == 1) begin
              if (m_run_len > 0 && code == m_run_code) m_run_len++;
              else begin m_run_code = code; m_run_len = 1; end
              if (m_run_len == D) begin
                m_pressed = 1; m_acc_pend = 1; m_acc_code = code; m_none_run = 0;
              end
            end else begin
              m_run_len = 0;
            end
          end else if (n == 0) begin
            m_none_run++;
            if (m_none_run == D) begin m_pressed = 0; m_run_len = 0; end
          end else begin
            m_none_run = 0;
          end
          m_mask = 16'h0;
        end
        m_kd2 = m_kd1;
        m_kd1 = keys;
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_col_out", {28'h0, col_out}, {28'h0, 4'b1111 ^ (4'b0001 << ((m_t / S) % 4))});
    chk("model_key_code", {28'h0, key_code}, {28'h0, m_code});
    chk("model_key_valid", {31'h0, key_valid}, {31'h0, m_valid});
    chk("model_key_held", {31'h0, key_held}, {31'h0, m_pressed});
    chk("model_overrun", {31'h0, overrun}, {31'h0, m_ovr});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scans(input int n);
    repeat (n * SCAN) tick();
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;

    // 1: reset values and column walk
    do_reset();
    chk("t1_col_c0", {28'h0, col_out}, 32'hE);
    chk("t1_valid_rst", {31'h0, key_valid}, 32'h0);
    chk("t1_code_rst", {28'h0, key_code}, 32'h0);
    chk("t1_held_rst", {31'h0, key_held}, 32'h0);
    chk("t1_ovr_rst", {31'h0, overrun}, 32'h0);
    repeat (3) tick();
    chk("t1_col_c3", {28'h0, col_out}, 32'hE);
    tick();
    chk("t1_col_c4", {28'h0, col_out}, 32'hD);
    repeat (4) tick();
    chk("t1_col_c8", {28'h0, col_out}, 32'hB);
    repeat (4) tick();
    chk("t1_col_c12", {28'h0, col_out}, 32'h7);
    repeat (4) tick();
    chk("t1_col_c16", {28'h0, col_out}, 32'hE);

    // 2: single press of '5', ack, release
    do_reset();
    keys = 16'h0020;
    for (int i = 0; i < 67 && !key_valid; i++) tick();
    chk("t2_valid_within_67", {31'h0, key_valid}, 32'h1);
    chk("t2_code", {28'h0, key_code}, 32'h5);
    chk("t2_held", {31'h0, key_held}, 32'h1);
    scans(2);
    chk("t2_valid_stays", {31'h0, key_valid}, 32'h1);
    pulse_ack();
    chk("t2_valid_after_ack", {31'h0, key_valid}, 32'h0);
    chk("t2_held_after_ack", {31'h0, key_held}, 32'h1);
    keys = 16'h0;
    scans(4);
    chk("t2_held_released", {31'h0, key_held}, 32'h0);
    chk("t2_valid_released", {31'h0, key_valid}, 32'h0);

    // 3: bouncing '9' never reaches the debounce count
    do_reset();
    keys = 16'h0400; scans(2);
    keys = 16'h0;    scans(1);
    keys = 16'h0400; scans(2);
    keys = 16'h0;    scans(2);
    chk("t3_valid", {31'h0, key_valid}, 32'h0);
    chk("t3_code", {28'h0, key_code}, 32'h0);
    chk("t3_held", {31'h0, key_held}, 32'h0);

    // 4: '1'+'2' together is rejected, then '1' alone is accepted
    do_reset();
    keys = 16'h0003; scans(6);
    chk("t4_multi_valid", {31'h0, key_valid}, 32'h0);
    chk("t4_multi_held", {31'h0, key_held}, 32'h0);
    keys = 16'h0001; scans(4);
    chk("t4_code", {28'h0, key_code}, 32'h1);
    chk("t4_valid", {31'h0, key_valid}, 32'h1);

    // 5: '*' then '#' without ack -> overrun
    do_reset();
    keys = 16'h1000; scans(4);
    chk("t5_star_code", {28'h0, key_code}, 32'hE);
    keys = 16'h0;    scans(3);
    keys = 16'h4000; scans(5);
    chk("t5_code", {28'h0, key_code}, 32'hF);
    chk("t5_overrun", {31'h0, overrun}, 32'h1);
    chk("t5_valid", {31'h0, key_valid}, 32'h1);
    pulse_ack();
    chk("t5_ack_valid", {31'h0, key_valid}, 32'h0);
    chk("t5_ack_overrun", {31'h0, overrun}, 32'h0);
    pulse_ack();
    chk("t5_ack2_valid", {31'h0, key_valid}, 32'h0);
    chk("t5_ack2_overrun", {31'h0, overrun}, 32'h0);
    chk("t5_ack2_code", {28'h0, key_code}, 32'hF);

    // 6: asynchronous reset while 'D' is held
    do_reset();
    keys = 16'h8000; scans(4);
    chk("t6_code_before", {28'h0, key_code}, 32'hD);
    chk("t6_valid_before", {31'h0, key_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_col", {28'h0, col_out}, 32'hE);
    chk("t6_async_code", {28'h0, key_code}, 32'h0);
    chk("t6_async_valid", {31'h0, key_valid}, 32'h0);
    chk("t6_async_held", {31'h0, key_held}, 32'h0);
    chk("t6_async_ovr", {31'h0, overrun}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("t6_not_yet", {31'h0, key_valid}, 32'h0);
    repeat (24) tick();
    chk("t6_reaccept_code", {28'h0, key_code}, 32'hD);
    chk("t6_reaccept_valid", {31'h0, key_valid}, 32'h1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and produces a debounced 4-bit hex key code with a valid/ack handshake.
- It is the input-side counterpart of the 7-segment/LED display path: its key_code is the 4-bit value that path consumes.
- Drives one column low at a time, samples the rows, debounces over whole scans and flags lost keys.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release. Range 2..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous
- col_out  out  4  column drive, active-low, exactly one bit low
- key_code  out  4  last accepted key code
- key_valid  out  1  high while an accepted key has not been acknowledged
- key_ack  in  1  single-cycle consumer acknowledge
- key_held  out  1  high while the accepted key is still down
- overrun  out  1  sticky flag: a key was accepted while key_valid was already high

Behaviour:
- Reset: clock and reset are fixed as one clock, clk, with asynchronous active-low reset rst_n. Asserting rst_n=0 immediately forces:
  - col_out=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0
  - FSM to IDLE; all counters and synchronizers cleared
  - This applies mid-scan and mid-press.
- Synchronizer: row_in passes through 2 flops before use.
- Column walk: col_out steps 1110 -> 1101 -> 1011 -> 0111 -> 1110. Each step lasts SCAN_DIV cycles, so one full scan is 4*SCAN_DIV cycles.
- Sampling: synchronized rows are sampled on the last cycle of each column slot. The scan result is evaluated on the last cycle of column 3.
- Scan result, one of three:
  - NONE: no low row bits in any column.
  - SINGLE(r,c): exactly one low bit across all 16 positions.
  - MULTI: two or more low bits. MULTI is never accepted as a press.
- Key map (row r, column c -> code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- Debounce FSM, updated only at scan evaluation:
  - IDLE: SINGLE -> CANDIDATE, cand=code, cnt=1. Otherwise stay.
  - CANDIDATE:
    - SINGLE with same code -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> PRESSED (accept).
    - SINGLE with a different code -> cand=new code, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED: key_held=1, rel=0.
    - NONE -> rel+1. When rel reaches DEBOUNCE_SCANS -> IDLE and key_held=0.
    - SINGLE or MULTI -> rel=0.
- Accept, in the cycle after the evaluation:
  - key_code <= cand, key_valid <= 1.
  - If key_valid was already 1 and key_ack is not asserted in the same cycle: overrun <= 1, and key_code is still updated to the newest key.
- Handshake:
  - key_ack while key_valid=1 clears key_valid and overrun on the next edge.
  - key_ack while key_valid=0 is ignored.
  - Accept and ack in the same cycle: key_valid stays 1, key_code takes the new value, overrun is not set.
- Latency: for a key held stable from before a scan start, key_valid rises 1 cycle after the evaluation of the DEBOUNCE_SCANS-th matching scan. The worst case is (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- Counters: width is sized for DEBOUNCE_SCANS and saturates. The column divider wraps at SCAN_DIV-1.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, so one scan = 16 cycles):
1. Reset:
   - Stimulus: rst_n=0 for 3 cycles, then release.
   - Required: all outputs at reset values. col_out=1110 for 4 cycles, then 1101, 1011, 0111, 1110 at cycles 4, 8, 12, 16.
2. Single press:
   - Stimulus: pull row1 low whenever col_out=1101 (key '5'), held; key_ack low.
   - Required: key_valid=1 and key_code=4'h5 within 67 cycles; key_held=1; key_valid stays high.
   - Then: ack for 1 cycle. Required: key_valid=0 next cycle.
   - Then: release key. Required: key_held=0 after 3 NONE scans.
3. Bounce:
   - Stimulus: key '9' present for 2 scans, absent for 1, present for 2, then released.
   - Required: key_valid never rises; key_code stays 0.
4. Multi-key:
   - Stimulus: '1' and '2' held together for 6 scans.
   - Required: no accept, key_valid=0.
   - Then: release '2' with '1' still held. Required: key_code=4'h1 accepted after 3 scans.
5. Overrun:
   - Stimulus: accept '*'; release it; accept '#' with no ack.
   - Required: key_code=4'hF, overrun=1, key_valid=1.
   - Then: ack. Required: key_valid=0 and overrun=0 next cycle.
   - Then: ack again with key_valid=0. Required: no effect.
6. Async reset mid-press:
   - Stimulus: hold 'D' until accepted, assert rst_n=0 between clock edges, release reset with 'D' still held.
   - Required: outputs reset immediately, without waiting for a clock edge. 'D' is re-accepted (key_code=4'hD, key_valid=1) after 3 further scans.
